// File: rtl/clock_core_param.sv
// Digital-clock core: 1 Hz prescaler, BCD time of day, manual set mode and a 12/24-hour display mapping.
// Internal time is always 24h BCD; the display registers apply the 12h mapping one cycle later.
module clock_core_param #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk_100MHz,
    input  logic       rst_time,
    input  logic       change,
    input  logic       select,
    input  logic       time_cnt,
    input  logic       mode_12h,
    output logic [3:0] L_sec,
    output logic [3:0] H_sec,
    output logic [3:0] L_min,
    output logic [3:0] H_min,
    output logic [3:0] L_hour,
    output logic [3:0] H_hour,
    output logic       pm,
    output logic [1:0] select_time,
    output logic       change_out,
    output logic       tick_1hz
);

    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2
    } field_e;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [7:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    field_e           sel_q, sel_d;
    logic             change_q, select_q, time_cnt_q;
    logic             tick_q, tick_d;

    logic [8:0] sec_inc, min_inc, hr_inc;
    logic       sel_rise, cnt_rise, chg_rise;
    logic [4:0] hr_bin, disp_bin;
    logic [3:0] disp_h, disp_l;
    logic       pm_d;

    // Returns {wrap, next_bcd}; wraps to 00 when the value equals last.
    function automatic logic [8:0] inc_bcd(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    assign sec_inc  = inc_bcd(sec_q, 8'h59);
    assign min_inc  = inc_bcd(min_q, 8'h59);
    assign hr_inc   = inc_bcd(hr_q, 8'h23);
    assign sel_rise = select & ~select_q;
    assign cnt_rise = time_cnt & ~time_cnt_q;
    assign chg_rise = change & ~change_q;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        if (!change) begin
            if (presc_q == TERM) begin
                presc_d = '0;
                tick_d  = 1'b1;
                sec_d   = sec_inc[7:0];
                if (sec_inc[8]) begin
                    min_d = min_inc[7:0];
                    if (min_inc[8])
                        hr_d = hr_inc[7:0];
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            presc_d = '0;
            if (chg_rise) begin
                sel_d = SEL_SEC;
            end else begin
                // Increment targets the field selected before any same-cycle select advance.
                if (cnt_rise) begin
                    case (sel_q)
                        SEL_SEC: sec_d = sec_inc[7:0];
                        SEL_MIN: min_d = min_inc[7:0];
                        default: hr_d  = hr_inc[7:0];
                    endcase
                end
                if (sel_rise) begin
                    case (sel_q)
                        SEL_SEC: sel_d = SEL_MIN;
                        SEL_MIN: sel_d = SEL_HOUR;
                        default: sel_d = SEL_SEC;
                    endcase
                end
            end
        end
    end

    always_comb begin
        hr_bin   = {1'b0, hr_q[7:4]} * 5'd10 + {1'b0, hr_q[3:0]};
        disp_bin = hr_bin;
        pm_d     = 1'b0;
        if (mode_12h) begin
            pm_d = (hr_bin >= 5'd12);
            if (hr_bin == 5'd0)
                disp_bin = 5'd12;
            else if (hr_bin > 5'd12)
                disp_bin = hr_bin - 5'd12;
        end
        if (disp_bin >= 5'd20) begin
            disp_h = 4'd2;
            disp_l = 4'(disp_bin - 5'd20);
        end else if (disp_bin >= 5'd10) begin
            disp_h = 4'd1;
            disp_l = 4'(disp_bin - 5'd10);
        end else begin
            disp_h = 4'd0;
            disp_l = disp_bin[3:0];
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst_time) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            sel_q      <= SEL_SEC;
            change_q   <= 1'b0;
            select_q   <= 1'b0;
            time_cnt_q <= 1'b0;
            tick_q     <= 1'b0;
            {H_sec, L_sec} <= '0;
            {H_min, L_min} <= '0;
            {H_hour, L_hour} <= mode_12h ? 8'h12 : 8'h00;
            pm         <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            sel_q      <= sel_d;
            change_q   <= change;
            select_q   <= select;
            time_cnt_q <= time_cnt;
            tick_q     <= tick_d;
            {H_sec, L_sec} <= sec_q;
            {H_min, L_min} <= min_q;
            H_hour     <= disp_h;
            L_hour     <= disp_l;
            pm         <= pm_d;
        end
    end

    assign select_time = sel_q;
    assign change_out  = change_q;
    assign tick_1hz    = tick_q;

endmodule

// File: tb/tb_clock_core_param.sv
// Directed bench for clock_core_param with TICK_DIV=4: run, wrap, set-mode editing, 12h mapping, corner cases.
module tb_clock_core_param;

    logic       clk_100MHz = 1'b0;
    logic       rst_time, change, select, time_cnt, mode_12h;
    logic [3:0] L_sec, H_sec, L_min, H_min, L_hour, H_hour;
    logic       pm, change_out, tick_1hz;
    logic [1:0] select_time;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    clock_core_param #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_time   (rst_time),
        .change     (change),
        .select     (select),
        .time_cnt   (time_cnt),
        .mode_12h   (mode_12h),
        .L_sec      (L_sec),
        .H_sec      (H_sec),
        .L_min      (L_min),
        .H_min      (H_min),
        .L_hour     (L_hour),
        .H_hour     (H_hour),
        .pm         (pm),
        .select_time(select_time),
        .change_out (change_out),
        .tick_1hz   (tick_1hz)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic pulse_cnt(input int n);
        repeat (n) begin
            time_cnt = 1'b1;
            step(1);
            time_cnt = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_sel(input int n);
        repeat (n) begin
            select = 1'b1;
            step(1);
            select = 1'b0;
            step(1);
        end
    endtask

    function automatic logic [31:0] disp();
        return {8'h00, H_hour, L_hour, H_min, L_min, H_sec, L_sec};
    endfunction

    task automatic chk_hour(input string tag, input logic [7:0] hr, input logic exp_pm);
        step(2);
        check({tag, "_hour"}, {24'h0, H_hour, L_hour}, {24'h0, hr});
        check({tag, "_pm"}, {31'h0, pm}, {31'h0, exp_pm});
    endtask

    initial begin
        int ticks;
        int phase_err;
        int first_tick;

        rst_time = 1'b1; change = 1'b0; select = 1'b0; time_cnt = 1'b0; mode_12h = 1'b1;
        step(3);
        check("rst_12h_disp", disp(), 32'h120000);
        check("rst_12h_pm", {31'h0, pm}, 32'h0);
        mode_12h = 1'b0;
        step(1);
        check("rst_disp", disp(), 32'h000000);
        check("rst_sel", {30'h0, select_time}, 32'h0);
        check("rst_chg_out", {31'h0, change_out}, 32'h0);
        check("rst_tick", {31'h0, tick_1hz}, 32'h0);

        // Run for 60 ticks: pulse expected on every 4th edge after reset release.
        rst_time = 1'b0;
        ticks = 0; phase_err = 0;
        for (int i = 1; i <= 240; i++) begin
            step(1);
            if (tick_1hz !== ((i % 4) == 0)) phase_err++;
            if (tick_1hz === 1'b1) ticks++;
        end
        check("run_tick_count", ticks, 60);
        check("run_tick_phase", phase_err, 0);
        step(1);
        check("run_one_minute", disp(), 32'h000100);

        // Set 23:59:59 and let one tick wrap everything.
        rst_time = 1'b1;
        step(2);
        rst_time = 1'b0; change = 1'b1;
        step(1);
        pulse_cnt(59);
        pulse_sel(1);
        pulse_cnt(59);
        pulse_sel(1);
        pulse_cnt(23);
        step(1);
        check("set_235959", disp(), 32'h235959);
        check("set_sel_hour", {30'h0, select_time}, 32'h2);
        check("set_no_tick", {31'h0, tick_1hz}, 32'h0);
        change = 1'b0;
        ticks = 0; first_tick = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (tick_1hz === 1'b1) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
        end
        check("wrap_tick_count", ticks, 1);
        check("wrap_tick_pos", first_tick, 4);
        check("wrap_disp", disp(), 32'h000000);
        check("exit_sel_hold", {30'h0, select_time}, 32'h2);

        // Field edit in set mode.
        change = 1'b1;
        step(1);
        check("chg_rise_sel", {30'h0, select_time}, 32'h0);
        check("chg_out", {31'h0, change_out}, 32'h1);
        pulse_sel(1);
        check("sel_to_min", {30'h0, select_time}, 32'h1);
        time_cnt = 1'b1;
        step(10);
        time_cnt = 1'b0;
        step(2);
        check("hold_cnt_once", disp(), 32'h000100);
        pulse_cnt(58);
        step(1);
        check("min_59", disp(), 32'h005900);
        pulse_cnt(1);
        step(1);
        check("min_wrap_nocarry", disp(), 32'h000000);
        pulse_sel(1);
        check("sel_cycle_2", {30'h0, select_time}, 32'h2);
        pulse_sel(1);
        check("sel_cycle_0", {30'h0, select_time}, 32'h0);
        pulse_sel(1);
        check("sel_cycle_1", {30'h0, select_time}, 32'h1);

        // 12h/24h mapping across the hour boundaries.
        pulse_sel(1);
        mode_12h = 1'b1; chk_hour("h00_12h", 8'h12, 1'b0);
        mode_12h = 1'b0; chk_hour("h00_24h", 8'h00, 1'b0);
        pulse_cnt(12);
        mode_12h = 1'b1; chk_hour("h12_12h", 8'h12, 1'b1);
        mode_12h = 1'b0; chk_hour("h12_24h", 8'h12, 1'b0);
        pulse_cnt(1);
        mode_12h = 1'b1; chk_hour("h13_12h", 8'h01, 1'b1);
        mode_12h = 1'b0; chk_hour("h13_24h", 8'h13, 1'b0);
        pulse_cnt(10);
        mode_12h = 1'b1; chk_hour("h23_12h", 8'h11, 1'b1);
        mode_12h = 1'b0; chk_hour("h23_24h", 8'h23, 1'b0);

        // time_cnt and select rising together with seconds selected.
        pulse_sel(1);
        select = 1'b1; time_cnt = 1'b1;
        step(1);
        select = 1'b0; time_cnt = 1'b0;
        step(2);
        check("simul_time", disp(), 32'h230001);
        check("simul_sel", {30'h0, select_time}, 32'h1);

        // change rises in the prescaler terminal cycle.
        change = 1'b0;
        step(3);
        change = 1'b1;
        step(1);
        check("term_no_tick_a", {31'h0, tick_1hz}, 32'h0);
        step(1);
        check("term_no_tick_b", {31'h0, tick_1hz}, 32'h0);
        check("term_time_same", disp(), 32'h230001);
        check("term_sel_reset", {30'h0, select_time}, 32'h0);

        // Reset in the middle of set mode.
        pulse_cnt(44);
        pulse_sel(1);
        pulse_cnt(30);
        pulse_sel(1);
        pulse_cnt(16);
        step(1);
        check("pre_rst_time", disp(), 32'h153045);
        check("pre_rst_sel", {30'h0, select_time}, 32'h2);
        rst_time = 1'b1;
        step(1);
        check("mid_rst_disp", disp(), 32'h000000);
        check("mid_rst_sel", {30'h0, select_time}, 32'h0);
        check("mid_rst_chg_out", {31'h0, change_out}, 32'h0);
        check("mid_rst_pm", {31'h0, pm}, 32'h0);
        rst_time = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_core_param.md
Name: clock_core_param

Overview:
- Parametrised successor to the digital-clock display core: keeps time from the system clock and drives BCD hour/minute/second digits to the display path.
- Adds a parametrised 1 Hz prescaler, a runtime 12/24-hour output mode with a PM flag, and edge-detected manual-set controls with a defined field-select cycle.
- Sits between the board clock/buttons (debounced upstream) and the seven-segment scan module.

Parameters:
- TICK_DIV, 100000000, clock cycles per second tick; must be >= 2. Benches use 4.
- CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge.
- rst_time  in  1  synchronous active-high reset.
- change  in  1  level; 1 = manual set mode (time frozen), 0 = run.
- select  in  1  level; each rising edge in set mode advances the selected field.
- time_cnt  in  1  level; each rising edge in set mode increments the selected field.
- mode_12h  in  1  level; 1 = 12-hour display, 0 = 24-hour display.
- L_sec, H_sec, L_min, H_min, L_hour, H_hour  out  4 each  BCD display digits.
- pm  out  1  1 when internal hour >= 12 and mode_12h=1; otherwise 0.
- select_time  out  2  selected field: 0 = sec, 1 = min, 2 = hour.
- change_out  out  1  change registered by one cycle, for the display blink logic.
- tick_1hz  out  1  one-cycle pulse on each second boundary in run mode.

Behaviour:
- All outputs are registered. On reset:
  - Time is 00:00:00 and the prescaler is 0.
  - select_time=0, change_out=0, tick_1hz=0.
  - Edge-detect history registers are 0.
  - Digits show 00:00:00 in 24h mode; in 12h mode they show 12:00:00 with pm=0.
- Internal time is held as 24h BCD (hour 00–23, minute and second 00–59).

Run mode (change=0):
- The prescaler counts 0..TICK_DIV-1 and wraps.
- When the prescaler equals TICK_DIV-1:
  - tick_1hz=1 in the next cycle.
  - Seconds increment on the same edge.
- Carry chain: sec 59->00 carries into min; min 59->00 carries into hour; hour 23->00. 23:59:59 -> 00:00:00 in a single tick.
- Digit rollover: the L digit rolls 9->0 and increments the H digit.
- select and time_cnt edges are ignored.

Set mode (change=1):
- The prescaler is held at 0 and tick_1hz=0; no time advance.
- Rising edge of change resets select_time to 0.
- select rising edge: select_time advances 0->1->2->0.
- time_cnt rising edge: the selected field increments modulo its range (sec and min 60, hour 24) with no carry. Example: min 59->00 leaves hour unchanged.
- Rising edge of a control = current input 1 and previous-cycle input 0. Holding a control high gives exactly one action.
- time_cnt and select edges in the same cycle: the increment applies to the old field, then select_time advances.

Exit from set mode (change falls):
- The prescaler restarts from 0, so the first tick occurs TICK_DIV cycles after change is first sampled 0.
- select_time holds its value.
- change rising in the same cycle the prescaler reaches TICK_DIV-1: change wins, the tick is suppressed and the time is unchanged.

12h display mapping (combinational from internal hour to registered outputs; updates the cycle after mode_12h changes):
- Internal hour 00 -> 12, pm=0.
- Internal hour 01–11 -> unchanged, pm=0.
- Internal hour 12 -> 12, pm=1.
- Internal hour 13–23 -> hour-12, pm=1.
- Internal time is never altered by mode_12h.

Other rules:
- Reset has priority over every other input in any mode, including mid-set and mid-tick.
- Latency: an input edge sampled at edge N is visible on the outputs after edge N+1. change_out = change delayed by one cycle.

Test Plan:
- Reset then run, TICK_DIV=4: rst_time high 3 cycles then low.
  - tick_1hz pulses every 4 cycles.
  - After 60 ticks: H_min=0, L_min=1, seconds=00.
- Full wrap: set time to 23:59:59 via set mode, release change, wait 4 cycles -> all digits 0; tick_1hz=1 exactly once.
- Set-mode field edit: change=1; select pulse -> select_time=1; hold time_cnt high 10 cycles -> minutes +1 only.
  - Min 59 plus one time_cnt pulse -> 00, hour unchanged.
  - Three select pulses -> select_time cycles 1->2->0->1.
- 12h mapping: set hour 00, 12, 13, 23 with mode_12h=1.
  - Expected displays: 12 pm=0, 12 pm=1, 01 pm=1, 11 pm=1.
  - With mode_12h=0 the displays are 00, 12, 13, 23 with pm=0.
- Simultaneous events:
  - time_cnt and select rise in the same cycle with select_time=0 -> seconds +1, select_time=1.
  - change rises in the prescaler-terminal cycle -> no tick, time unchanged.
- Reset mid-operation: assert rst_time during set mode with select_time=2 and time 15:30:45 -> next cycle all digits 0, select_time=0, change_out=0, pm=0.
